// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions: forwarding select encodings,
// hazard FSM state type and the default register address width.
package cpu_pipe_pkg;

  localparam int unsigned RA_W_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hfc_state_e;

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding comparator: picks the youngest in-flight writer
// of the EX-stage source register, EX/MEM before MEM/WB, x0 never forwarded.
module fwd_match
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] ex_mem_rd,
  input  logic            ex_mem_reg_write,
  input  logic [RA_W-1:0] mem_wb_rd,
  input  logic            mem_wb_reg_write,
  output logic [1:0]      sel
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  // Priority select: the EX/MEM result is newer than the MEM/WB one.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit)      sel = FWD_EXMEM;
    else if (wb_hit) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX operand
// forwarding, ID write-back bypass, load-use bubbles and memory freeze,
// plus saturating stall/freeze performance counters.
module hazard_fwd_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned RA_W     = RA_W_DEF,
  parameter int unsigned N_SRC    = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [N_SRC*RA_W-1:0] id_rs,
  input  logic [N_SRC-1:0]      id_rs_use,
  input  logic [N_SRC*RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0]       id_ex_rd,
  input  logic                  id_ex_reg_write,
  input  logic                  id_ex_mem_read,
  input  logic [RA_W-1:0]       ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  input  logic [RA_W-1:0]       mem_wb_rd,
  input  logic                  mem_wb_reg_write,
  input  logic                  dmem_busy,
  output logic [2*N_SRC-1:0]    fwd_sel,
  output logic [N_SRC-1:0]      wb_bypass,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  // Bubbles still owed after the first one; LOAD_LAT is limited to 1..7.
  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  hfc_state_e          state_q, state_d;
  logic [2:0]          lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    freeze_cnt_q;
  logic [2*N_SRC-1:0]  fwd_raw;
  logic                rs_dep;
  logic                lu_hit;

  for (genvar k = 0; k < N_SRC; k++) begin : g_fwd
    fwd_match #(
      .RA_W(RA_W)
    ) u_match (
      .rs               (ex_rs[k*RA_W +: RA_W]),
      .ex_mem_rd        (ex_mem_rd),
      .ex_mem_reg_write (ex_mem_reg_write),
      .mem_wb_rd        (mem_wb_rd),
      .mem_wb_reg_write (mem_wb_reg_write),
      .sel              (fwd_raw[2*k +: 2])
    );
  end

  assign fwd_sel = reset ? '0 : fwd_raw;

  // Write-back bypass into the ID-stage register read.
  always_comb begin
    wb_bypass = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      wb_bypass[k] = !reset && id_valid && mem_wb_reg_write &&
                     (mem_wb_rd != '0) &&
                     (mem_wb_rd == id_rs[k*RA_W +: RA_W]);
    end
  end

  // Load-use detection: an actually-read ID operand depends on a load in EX.
  always_comb begin
    rs_dep = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (id_rs_use[k] && (id_rs[k*RA_W +: RA_W] == id_ex_rd)) rs_dep = 1'b1;
    end
    lu_hit = id_valid && id_ex_mem_read && id_ex_reg_write &&
             (id_ex_rd != '0) && rs_dep;
  end

  // Next-state and pipeline-control outputs; a busy memory overrides all.
  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (reset) begin
      state_d  = RUN;
      lu_cnt_d = '0;
    end else if (dmem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            lu_cnt_d     = LU_INIT;
            state_d      = (LOAD_LAT > 1) ? LU_STALL : RUN;
          end
        end
        LU_STALL: begin
          if (lu_cnt_q != '0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            lu_cnt_d     = lu_cnt_q - 3'd1;
            if (lu_cnt_q == 3'd1) state_d = RUN;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state and remaining-bubble counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (id_ex_bubble && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (pipe_freeze && (freeze_cnt_q != '1))
        freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: three instances (default, LOAD_LAT=3, CNT_W=4)
// share one directed stimulus; a cycle model plus literal checks.
module tb_hazard_fwd_ctrl;

  localparam int RA_W = 5;
  localparam int NI   = 3;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_use;
  logic [9:0]  ex_rs;
  logic [4:0]  id_ex_rd;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic        dmem_busy;

  logic [3:0]  o_fwd [NI];
  logic [1:0]  o_byp [NI];
  logic        o_pcw [NI];
  logic        o_ifw [NI];
  logic        o_bub [NI];
  logic        o_frz [NI];
  logic [31:0] o_stc [NI];
  logic [31:0] o_frc [NI];
  logic [3:0]  sat_stc, sat_frc;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_fwd_ctrl #(.RA_W(5), .N_SRC(2), .LOAD_LAT(1), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_use(id_rs_use), .ex_rs(ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .dmem_busy(dmem_busy), .fwd_sel(o_fwd[0]), .wb_bypass(o_byp[0]),
    .pc_write(o_pcw[0]), .if_id_write(o_ifw[0]), .id_ex_bubble(o_bub[0]),
    .pipe_freeze(o_frz[0]), .stall_cnt(o_stc[0]), .freeze_cnt(o_frc[0]));

  hazard_fwd_ctrl #(.RA_W(5), .N_SRC(2), .LOAD_LAT(3), .CNT_W(32)) u_deep (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_use(id_rs_use), .ex_rs(ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .dmem_busy(dmem_busy), .fwd_sel(o_fwd[1]), .wb_bypass(o_byp[1]),
    .pc_write(o_pcw[1]), .if_id_write(o_ifw[1]), .id_ex_bubble(o_bub[1]),
    .pipe_freeze(o_frz[1]), .stall_cnt(o_stc[1]), .freeze_cnt(o_frc[1]));

  hazard_fwd_ctrl #(.RA_W(5), .N_SRC(2), .LOAD_LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_use(id_rs_use), .ex_rs(ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .dmem_busy(dmem_busy), .fwd_sel(o_fwd[2]), .wb_bypass(o_byp[2]),
    .pc_write(o_pcw[2]), .if_id_write(o_ifw[2]), .id_ex_bubble(o_bub[2]),
    .pipe_freeze(o_frz[2]), .stall_cnt(sat_stc), .freeze_cnt(sat_frc));

  assign o_stc[2] = {28'd0, sat_stc};
  assign o_frc[2] = {28'd0, sat_frc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_lat [NI] = '{1, 3, 1};
  longint      m_cap [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int          m_rem [NI];
  longint      m_stc [NI];
  longint      m_frc [NI];
  bit          m_ok = 1'b0;

  function automatic logic m_hit();
    logic dep;
    dep = (id_rs_use[0] && id_rs[4:0] == id_ex_rd) ||
          (id_rs_use[1] && id_rs[9:5] == id_ex_rd);
    return id_valid && id_ex_mem_read && id_ex_reg_write && id_ex_rd != 0 && dep;
  endfunction

  function automatic logic [1:0] m_fwd1(input logic [4:0] rs);
    if (reset) return 2'b00;
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_byp1(input logic [4:0] rs);
    return !reset && id_valid && mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == rs;
  endfunction

  // Compare every cycle on the falling edge, then advance the model to the
  // state the rising edge will produce from the inputs now applied.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic e_frz, e_bub;
      e_frz = !reset && dmem_busy;
      e_bub = !reset && !dmem_busy && (m_rem[i] > 0 || m_hit());
      if (m_ok) begin
        check("fwd_sel", i, 64'(o_fwd[i]), 64'({m_fwd1(ex_rs[9:5]), m_fwd1(ex_rs[4:0])}));
        check("wb_bypass", i, 64'(o_byp[i]), 64'({m_byp1(id_rs[9:5]), m_byp1(id_rs[4:0])}));
        check("pipe_freeze", i, 64'(o_frz[i]), 64'(e_frz));
        check("id_ex_bubble", i, 64'(o_bub[i]), 64'(e_bub));
        check("pc_write", i, 64'(o_pcw[i]), 64'(!(e_frz || e_bub)));
        check("if_id_write", i, 64'(o_ifw[i]), 64'(!(e_frz || e_bub)));
        check("stall_cnt", i, 64'(o_stc[i]), 64'(m_stc[i]));
        check("freeze_cnt", i, 64'(o_frc[i]), 64'(m_frc[i]));
      end
      if (reset) begin
        m_rem[i] = 0;
        m_stc[i] = 0;
        m_frc[i] = 0;
      end else if (m_ok) begin
        if (e_frz) begin
          if (m_frc[i] < m_cap[i]) m_frc[i]++;
        end else if (e_bub) begin
          if (m_stc[i] < m_cap[i]) m_stc[i]++;
          if (m_rem[i] > 0) m_rem[i]--;
          else              m_rem[i] = m_lat[i] - 1;
        end
      end
    end
    if (reset) m_ok = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_rs_use = '0; ex_rs = '0;
    id_ex_rd = '0; id_ex_reg_write = 0; id_ex_mem_read = 0;
    ex_mem_rd = '0; ex_mem_reg_write = 0;
    mem_wb_rd = '0; mem_wb_reg_write = 0; dmem_busy = 0;
  endtask

  task automatic set_load_use();
    id_valid = 1; id_rs[4:0] = 5'd3; id_rs_use = 2'b01;
    id_ex_rd = 5'd3; id_ex_mem_read = 1; id_ex_reg_write = 1;
  endtask

  task automatic nop_in_id_ex();
    id_ex_rd = '0; id_ex_mem_read = 0; id_ex_reg_write = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    // Forwarding/bypass matches and busy memory present while in reset.
    ex_rs[4:0] = 5'd5; ex_mem_rd = 5'd5; ex_mem_reg_write = 1;
    id_valid = 1; id_rs[9:5] = 5'd7; mem_wb_rd = 5'd7; mem_wb_reg_write = 1;
    dmem_busy = 1;
    step(); step();
    #1;
    check("rst_fwd_sel", 0, 64'(o_fwd[0]), 64'h0);
    check("rst_wb_bypass", 0, 64'(o_byp[0]), 64'h0);
    check("rst_pc_write", 0, 64'(o_pcw[0]), 64'h1);
    check("rst_pipe_freeze", 0, 64'(o_frz[0]), 64'h0);
    check("rst_stall_cnt", 0, 64'(o_stc[0]), 64'h0);
    check("rst_freeze_cnt", 0, 64'(o_frc[0]), 64'h0);
    clear_inputs();
    reset = 0;
    step();

    // Forwarding priority.
    ex_rs[4:0] = 5'd5; ex_rs[9:5] = 5'd9;
    ex_mem_rd = 5'd5; ex_mem_reg_write = 1;
    mem_wb_rd = 5'd5; mem_wb_reg_write = 1;
    #1 check("fwd_exmem_wins", 0, 64'(o_fwd[0]), 64'h2);
    ex_mem_reg_write = 0;
    #1 check("fwd_memwb", 0, 64'(o_fwd[0]), 64'h1);
    ex_rs[4:0] = 5'd0; ex_rs[9:5] = 5'd5;
    #1 check("fwd_x0_and_op1", 0, 64'(o_fwd[0]), 64'h4);
    step();

    // Write-back bypass and disabled writer.
    clear_inputs();
    id_valid = 1; id_rs[9:5] = 5'd7; mem_wb_rd = 5'd7; mem_wb_reg_write = 0;
    #1 check("byp_no_write", 0, 64'(o_byp[0]), 64'h0);
    mem_wb_reg_write = 1;
    #1 check("byp_write", 0, 64'(o_byp[0]), 64'h2);
    step();
    id_valid = 0;
    #1 check("byp_id_invalid", 0, 64'(o_byp[0]), 64'h0);
    step();
    clear_inputs();
    step();

    // Load-use, both depths from the same hazard.
    set_load_use();
    #1 check("lu_bubble", 0, 64'(o_bub[0]), 64'h1);
    check("lu_pc_write", 0, 64'(o_pcw[0]), 64'h0);
    step();
    nop_in_id_ex();
    #1 check("lu_done", 0, 64'(o_bub[0]), 64'h0);
    check("lu_pc_resume", 0, 64'(o_pcw[0]), 64'h1);
    check("deep_bubble2", 1, 64'(o_bub[1]), 64'h1);
    step();
    check("deep_bubble3", 1, 64'(o_bub[1]), 64'h1);
    step();
    check("deep_done", 1, 64'(o_bub[1]), 64'h0);
    check("lu_stall_cnt", 0, 64'(o_stc[0]), 64'd1);
    check("deep_stall_cnt", 1, 64'(o_stc[1]), 64'd3);

    // Non-hazards: operand unused, x0 load, then a hit via operand 1.
    set_load_use();
    id_rs_use = 2'b00;
    #1 check("lu_unused", 0, 64'(o_bub[0]), 64'h0);
    id_ex_rd = 5'd0; id_rs[4:0] = 5'd0; id_rs_use = 2'b01;
    #1 check("lu_x0", 0, 64'(o_bub[0]), 64'h0);
    id_ex_rd = 5'd3; id_rs[9:5] = 5'd3; id_rs_use = 2'b10;
    #1 check("lu_op1", 0, 64'(o_bub[0]), 64'h1);
    id_rs_use = 2'b00;
    step();

    // Deep stall interrupted by a 4-cycle memory freeze.
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    set_load_use();
    step();
    nop_in_id_ex();
    dmem_busy = 1;
    #1 check("frz_no_bubble", 1, 64'(o_bub[1]), 64'h0);
    check("frz_freeze", 1, 64'(o_frz[1]), 64'h1);
    check("frz_pc_write", 1, 64'(o_pcw[1]), 64'h0);
    step(); step(); step();
    step();
    dmem_busy = 0;
    #1 check("frz_resume2", 1, 64'(o_bub[1]), 64'h1);
    step();
    check("frz_resume3", 1, 64'(o_bub[1]), 64'h1);
    step();
    check("frz_done", 1, 64'(o_bub[1]), 64'h0);
    check("frz_stall_cnt", 1, 64'(o_stc[1]), 64'd3);
    check("frz_freeze_cnt", 1, 64'(o_frc[1]), 64'd4);

    // Reset during the last deep bubble.
    set_load_use();
    step();
    nop_in_id_ex();
    step();
    check("pre_rst_bubble", 1, 64'(o_bub[1]), 64'h1);
    reset = 1;
    #1 check("rst_mid_bubble", 1, 64'(o_bub[1]), 64'h0);
    step();
    reset = 0;
    #1 check("post_rst_bubble", 1, 64'(o_bub[1]), 64'h0);
    check("post_rst_pc_write", 1, 64'(o_pcw[1]), 64'h1);
    check("post_rst_stall_cnt", 1, 64'(o_stc[1]), 64'd0);
    check("post_rst_freeze_cnt", 1, 64'(o_frc[1]), 64'd0);
    step();

    // Freeze counter saturation on the 4-bit instance.
    dmem_busy = 1;
    repeat (19) step();
    step();
    dmem_busy = 0;
    #1 check("sat_freeze_cnt", 2, 64'(o_frc[2]), 64'd15);
    check("wide_freeze_cnt", 0, 64'(o_frc[0]), 64'd20);
    step();
    check("sat_freeze_hold", 2, 64'(o_frc[2]), 64'd15);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
